// File: rtl/int_divider_unit_pkg.sv
// Shared types and constants for the RV32M integer divide/remainder unit.
package int_divider_unit_pkg;

  localparam int unsigned XLEN           = 32;
  localparam int unsigned DIV_ITERATIONS = XLEN;

  typedef logic [XLEN-1:0] data_bus_t;

  localparam data_bus_t DIV_BY_ZERO_Q = 32'hFFFFFFFF;

  typedef enum logic [1:0] {DIV_, DIVU_, REM_, REMU_} div_ops_e;
  typedef enum logic {FREE, BUSY} fu_state_e;
  typedef enum logic [1:0] {DIV_IDLE, DIV_PREP, DIV_DIVIDE, DIV_FINISH} div_fsm_e;

  function automatic logic is_signed_op(input div_ops_e op);
    return (op == DIV_) || (op == REM_);
  endfunction

  function automatic logic is_rem_op(input div_ops_e op);
    return (op == REM_) || (op == REMU_);
  endfunction

endpackage

// File: rtl/int_divider_unit_if.sv
// Issue/writeback connection of the divide unit; master = issue side, slave = unit.
interface int_divider_unit_if;
  import int_divider_unit_pkg::*;

  logic      valid_i;
  div_ops_e  op_i;
  data_bus_t dividend_i;
  data_bus_t divisor_i;
  logic      kill_i;
  fu_state_e state_o;
  logic      valid_o;
  data_bus_t result_o;

  modport master (
    output valid_i, op_i, dividend_i, divisor_i, kill_i,
    input  state_o, valid_o, result_o
  );

  modport slave (
    input  valid_i, op_i, dividend_i, divisor_i, kill_i,
    output state_o, valid_o, result_o
  );
endinterface

// File: rtl/int_divider_unit_div_restoring_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract divisor.
module div_restoring_step #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] quo_i,
  input  logic [W-1:0] divisor_i,
  output logic [W-1:0] rem_next_c,
  output logic [W-1:0] quo_next_c
);

  logic [W:0] rem_sh;
  logic [W:0] diff;

  // Shifted remainder keeps its carry bit so full-range unsigned divisors work.
  always_comb begin
    rem_sh = {rem_i, quo_i[W-1]};
    diff   = rem_sh - {1'b0, divisor_i};
    if (!diff[W]) begin
      rem_next_c = diff[W-1:0];
      quo_next_c = {quo_i[W-2:0], 1'b1};
    end else begin
      rem_next_c = rem_sh[W-1:0];
      quo_next_c = {quo_i[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/int_divider_unit.sv
// Multi-cycle radix-2 restoring DIV/DIVU/REM/REMU unit.
// Optional last-result cache enabled by defining MGT_DIV_RESULT_CACHE_EN.
module int_divider_unit
  import int_divider_unit_pkg::*;
#(
  parameter int unsigned XLEN_P = XLEN,
  parameter int unsigned ITER_P = XLEN_P
) (
  input logic               clk_i,
  input logic               rst_i,
  int_divider_unit_if.slave div_if
);

  localparam int unsigned      CNT_W    = (ITER_P > 1) ? $clog2(ITER_P) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER_P - 1);
  localparam logic [XLEN_P-1:0] MIN_NEG = {1'b1, {(XLEN_P-1){1'b0}}};

  div_fsm_e          state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  div_ops_e          op_q, op_d;
  logic [XLEN_P-1:0] a_q, a_d, b_q, b_d;
  logic [XLEN_P-1:0] quo_q, quo_d, rem_q, rem_d, dmag_q, dmag_d;
  logic [XLEN_P-1:0] result_q, result_d;
  logic              q_neg_q, q_neg_d, r_neg_q, r_neg_d;
  logic              valid_q, valid_d;
  fu_state_e         fu_q, fu_d;

  logic              accept_c, fin_c, a_neg_c, b_neg_c;
  logic [XLEN_P-1:0] fin_quo_c, fin_rem_c, quo_step_c, rem_step_c;

`ifdef MGT_DIV_RESULT_CACHE_EN
  logic              cv_q, cv_d, cs_q, cs_d, hit_c;
  logic [XLEN_P-1:0] ca_q, ca_d, cb_q, cb_d, cq_q, cq_d, cr_q, cr_d;
`endif

  div_restoring_step #(.W(XLEN_P)) u_step (
    .rem_i      (rem_q),
    .quo_i      (quo_q),
    .divisor_i  (dmag_q),
    .rem_next_c (rem_step_c),
    .quo_next_c (quo_step_c)
  );

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dmag_d    = dmag_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    result_d  = result_q;
    valid_d   = 1'b0;
    fin_c     = 1'b0;
    fin_quo_c = '0;
    fin_rem_c = '0;
    a_neg_c   = is_signed_op(op_q) && a_q[XLEN_P-1];
    b_neg_c   = is_signed_op(op_q) && b_q[XLEN_P-1];
    accept_c  = div_if.valid_i && ((state_q == DIV_IDLE) || (state_q == DIV_FINISH));
`ifdef MGT_DIV_RESULT_CACHE_EN
    cv_d  = cv_q;
    cs_d  = cs_q;
    ca_d  = ca_q;
    cb_d  = cb_q;
    cq_d  = cq_q;
    cr_d  = cr_q;
    hit_c = cv_q && (ca_q == XLEN_P'(div_if.dividend_i)) && (cb_q == XLEN_P'(div_if.divisor_i))
            && (cs_q == is_signed_op(div_if.op_i));
`endif

    if (div_if.kill_i) begin
      state_d = DIV_IDLE;
`ifdef MGT_DIV_RESULT_CACHE_EN
      if (state_q == DIV_DIVIDE) cv_d = 1'b0;
`endif
    end else begin
      unique case (state_q)
        DIV_IDLE, DIV_FINISH: begin
          state_d = DIV_IDLE;
          if (accept_c) begin
            op_d    = div_if.op_i;
            a_d     = XLEN_P'(div_if.dividend_i);
            b_d     = XLEN_P'(div_if.divisor_i);
            state_d = DIV_PREP;
`ifdef MGT_DIV_RESULT_CACHE_EN
            if (hit_c) begin
              state_d  = DIV_FINISH;
              valid_d  = 1'b1;
              result_d = is_rem_op(div_if.op_i) ? cr_q : cq_q;
            end
`endif
          end
        end
        DIV_PREP: begin
          if (b_q == '0) begin
            fin_c     = 1'b1;
            fin_quo_c = XLEN_P'(DIV_BY_ZERO_Q);
            fin_rem_c = a_q;
          end else if (is_signed_op(op_q) && (a_q == MIN_NEG) && (b_q == '1)) begin
            fin_c     = 1'b1;
            fin_quo_c = MIN_NEG;
            fin_rem_c = '0;
          end else begin
            quo_d   = a_neg_c ? -a_q : a_q;
            dmag_d  = b_neg_c ? -b_q : b_q;
            rem_d   = '0;
            cnt_d   = '0;
            q_neg_d = a_neg_c ^ b_neg_c;
            r_neg_d = a_neg_c;
            state_d = DIV_DIVIDE;
          end
        end
        DIV_DIVIDE: begin
          quo_d = quo_step_c;
          rem_d = rem_step_c;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            fin_c     = 1'b1;
            fin_quo_c = q_neg_q ? -quo_step_c : quo_step_c;
            fin_rem_c = r_neg_q ? -rem_step_c : rem_step_c;
          end
        end
        default: state_d = DIV_IDLE;
      endcase

      // Completion: sign-corrected result is registered as the unit enters FINISH.
      if (fin_c) begin
        state_d  = DIV_FINISH;
        valid_d  = 1'b1;
        result_d = is_rem_op(op_q) ? fin_rem_c : fin_quo_c;
`ifdef MGT_DIV_RESULT_CACHE_EN
        cv_d = 1'b1;
        cs_d = is_signed_op(op_q);
        ca_d = a_q;
        cb_d = b_q;
        cq_d = fin_quo_c;
        cr_d = fin_rem_c;
`endif
      end
    end

    fu_d = ((state_d == DIV_IDLE) || (state_d == DIV_FINISH)) ? FREE : BUSY;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= DIV_IDLE;
      cnt_q    <= '0;
      op_q     <= DIVU_;
      a_q      <= '0;
      b_q      <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dmag_q   <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      result_q <= '0;
      valid_q  <= 1'b0;
      fu_q     <= FREE;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dmag_q   <= dmag_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      fu_q     <= fu_d;
    end
  end

`ifdef MGT_DIV_RESULT_CACHE_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cv_q <= 1'b0;
      cs_q <= 1'b0;
      ca_q <= '0;
      cb_q <= '0;
      cq_q <= '0;
      cr_q <= '0;
    end else begin
      cv_q <= cv_d;
      cs_q <= cs_d;
      ca_q <= ca_d;
      cb_q <= cb_d;
      cq_q <= cq_d;
      cr_q <= cr_d;
    end
  end
`endif

  assign div_if.state_o  = fu_q;
  assign div_if.valid_o  = valid_q;
  assign div_if.result_o = data_bus_t'(result_q);

endmodule
